// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared state type, defaults and byte constants for the JPEG bit packer
package jpeg_pkg;
    typedef enum logic [1:0] {RUN, STUFF, FLUSH, DONE} state_t;
    localparam int CODE_W_DEF = 16;
    localparam int ACC_W_DEF = 32;
    localparam logic [7:0] STUFF_BYTE = 8'h00;
    localparam logic [7:0] MARKER_BYTE = 8'hFF;
    localparam logic PAD_BIT = 1'b1;
endpackage

// File: rtl/jpeg_bit_packer.sv
// jpeg_bit_packer: packs variable-length codes MSB-first into bytes with 0xFF stuffing and end-of-scan padding
module jpeg_bit_packer
    import jpeg_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic [4:0]        in_len,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              flush_done
);
    localparam int CNT_W = $clog2(ACC_W + 1);
    state_t state, state_next;
    logic [ACC_W-1:0] acc, acc_next, code_ext;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic flush_pend, pend_next;
    logic [4:0] len_eff;
    logic can_load, accept, data_load, pad_load, stuff_load, load, ff_load;
    logic [7:0] data_byte, pad_byte, load_byte;
    // Bits live right-aligned in acc; the oldest held bit sits at position cnt-1
    always_comb begin
        in_ready = (cnt <= CNT_W'(ACC_W - CODE_W)) && state == RUN;
        flush_done = state == DONE;
        len_eff = (int'(in_len) > CODE_W) ? 5'(CODE_W) : in_len;
        code_ext = ACC_W'(in_code) & ~({ACC_W{1'b1}} << len_eff);
        can_load = !out_valid || out_ready;
        accept = in_valid && in_ready && len_eff != '0;
        data_load = can_load && (state == RUN || state == FLUSH) && cnt >= CNT_W'(8);
        pad_load = can_load && state == FLUSH && cnt != '0 && cnt < CNT_W'(8);
        stuff_load = can_load && state == STUFF;
        load = data_load || pad_load || stuff_load;
        data_byte = 8'(acc >> (cnt - CNT_W'(8)));
        pad_byte = 8'(acc << (CNT_W'(8) - cnt)) | ({8{PAD_BIT}} >> cnt);
        load_byte = data_load ? data_byte : pad_load ? pad_byte : STUFF_BYTE;
        ff_load = (data_load || pad_load) && load_byte == MARKER_BYTE;
        acc_next = accept ? ((acc << len_eff) | code_ext) : acc;
        cnt_next = cnt + (accept ? CNT_W'(len_eff) : '0) - (data_load ? CNT_W'(8) : pad_load ? cnt : '0);
        state_next = state == RUN   ? (ff_load ? STUFF : flush ? FLUSH : RUN) :
                     state == STUFF ? (stuff_load ? ((flush_pend || flush) ? FLUSH : RUN) : STUFF) :
                     state == FLUSH ? (ff_load ? STUFF : (cnt == '0 && can_load) ? DONE : FLUSH) :
                                      RUN;
        pend_next = state_next == STUFF && (flush_pend || flush || state == FLUSH);
    end
    // State, accumulator and output byte register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            acc <= '0;
            cnt <= '0;
            flush_pend <= 1'b0;
            out_valid <= 1'b0;
            out_byte <= 8'h00;
        end else begin
            state <= state_next;
            acc <= acc_next;
            cnt <= cnt_next;
            flush_pend <= pend_next;
            out_valid <= load || (out_valid && !out_ready);
            if (load) out_byte <= load_byte;
        end
    end
endmodule
